// File: rtl/bus_xcvr_seq_if.sv
// Handshake and bus bundle between a requester and the 74x245 sequencer.
// The requester side drives req/wr/wdata and the sampled A-side bus value.
interface bus_xcvr_seq_if #(
    parameter int WIDTH = 8
);
    logic             req;
    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] a_drv;
    logic             a_oe;
    logic             nen;
    logic             dir;
    logic [WIDTH-1:0] rdata;
    logic             ack;
    logic             busy;

    modport master (
        output req, wr, wdata, a_in,
        input  a_drv, a_oe, nen, dir, rdata, ack, busy
    );

    modport slave (
        input  req, wr, wdata, a_in,
        output a_drv, a_oe, nen, dir, rdata, ack, busy
    );
endinterface

// File: rtl/bus_xcvr_seq.sv
// Turnaround-safe 74x245 transaction sequencer: IDLE -> TURN -> DRIVE -> DONE.
// Optional XCVR_TURN_SKIP_EN skips TURN when the direction is already correct.
module bus_xcvr_seq #(
    parameter int WIDTH         = 8,
    parameter int TURN_CYCLES   = 1,
    parameter int SETTLE_CYCLES = 2
) (
    input logic               clk,
    input logic               nreset,
    bus_xcvr_seq_if.slave     bus
);
    localparam int MAXC = (TURN_CYCLES > SETTLE_CYCLES) ?
                          TURN_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] TURN_LD   = CW'(TURN_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, TURN, DRIVE, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             nen_q, nen_d;
    logic             dir_q, dir_d;
    logic             a_oe_q, a_oe_d;
    logic [WIDTH-1:0] a_drv_q, a_drv_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             skip;

`ifdef XCVR_TURN_SKIP_EN
    // Set once a transaction has completed; only reset clears it.
    logic chain_q, chain_d;
    assign chain_d = chain_q | (state_q == DONE);
    assign skip    = chain_q & (bus.wr == dir_q);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) chain_q <= 1'b0;
        else         chain_q <= chain_d;
    end
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nen_d   = 1'b1;
        dir_d   = dir_q;
        a_oe_d  = a_oe_q;
        a_drv_d = a_drv_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                a_oe_d = 1'b0;
                busy_d = 1'b0;
                if (bus.req) begin
                    dir_d   = bus.wr;
                    a_drv_d = bus.wdata;
                    a_oe_d  = bus.wr;
                    busy_d  = 1'b1;
                    if (skip) begin
                        state_d = DRIVE;
                        cnt_d   = SETTLE_LD;
                        nen_d   = 1'b0;
                    end else begin
                        state_d = TURN;
                        cnt_d   = TURN_LD;
                    end
                end
            end
            TURN: begin
                if (cnt_q == '0) begin
                    state_d = DRIVE;
                    cnt_d   = SETTLE_LD;
                    nen_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    ack_d   = 1'b1;
                    if (!dir_q) rdata_d = bus.a_in;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    nen_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                a_oe_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nen_q   <= 1'b1;
            dir_q   <= 1'b0;
            a_oe_q  <= 1'b0;
            a_drv_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nen_q   <= nen_d;
            dir_q   <= dir_d;
            a_oe_q  <= a_oe_d;
            a_drv_q <= a_drv_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.nen   = nen_q;
    assign bus.dir   = dir_q;
    assign bus.a_oe  = a_oe_q;
    assign bus.a_drv = a_drv_q;
    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_bus_xcvr_seq.sv
// Self-checking bench for bus_xcvr_seq: vector table, corner sequences,
// random transactions against a latency/rdata reference model.
module tb_bus_xcvr_seq;
    localparam int T = 1;
    localparam int S = 2;
`ifdef XCVR_TURN_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk;
    logic nreset;
    int   tests;
    int   fails;

    bus_xcvr_seq_if #(.WIDTH(8)) bif ();

    bus_xcvr_seq #(
        .WIDTH(8),
        .TURN_CYCLES(T),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    bit       m_chain;
    bit       m_dir;
    bit [7:0] m_rd;

    typedef struct {
        bit       w;
        bit [7:0] d;
        bit [7:0] ai;
        bit [7:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input bit w);
        if (SKIP && m_chain && (w == m_dir)) return S + 1;
        return T + S + 1;
    endfunction

    function automatic void model_done(input bit w, input bit [7:0] ai);
        m_chain = 1'b1;
        m_dir   = w;
        if (!w) m_rd = ai;
    endfunction

    function automatic void model_reset();
        m_chain = 1'b0;
        m_dir   = 1'b0;
        m_rd    = 8'h00;
    endfunction

    // bus-safety monitor
    logic prev_dir;
    always @(negedge clk) begin
        if (nreset) begin
            if (!bif.nen) chk("dir_stable_nen0", bif.dir, prev_dir);
            chk("aoe_needs_dir", bif.a_oe & ~bif.dir, 1'b0);
        end
        prev_dir = bif.dir;
    end

    task automatic do_txn(input bit w, input bit [7:0] d,
                          input bit [7:0] ai, input bit [7:0] exp_rd);
        int  lat;
        int  nlow;
        int  el;
        bit  drv_ok;
        el = exp_lat(w);
        bif.req   = 1'b1;
        bif.wr    = w;
        bif.wdata = d;
        bif.a_in  = ai;
        step();
        bif.req   = 1'b0;
        bif.wr    = ~w;
        bif.wdata = ~d;
        chk("c1_dir", bif.dir, w);
        chk("c1_aoe", bif.a_oe, w);
        chk("c1_busy", bif.busy, 1'b1);
        lat    = 1;
        nlow   = 0;
        drv_ok = 1'b1;
        while (!bif.ack && lat < 20) begin
            if (!bif.nen) begin
                nlow++;
                if (w && (bif.a_drv != d || !bif.a_oe)) drv_ok = 1'b0;
            end
            step();
            lat++;
        end
        chk("ack_latency", lat, el);
        chk("nen_low_cycles", nlow, S);
        chk("drive_data", drv_ok, 1'b1);
        chk("rdata_at_ack", bif.rdata, exp_rd);
        chk("done_busy", bif.busy, 1'b1);
        chk("done_nen", bif.nen, 1'b1);
        model_done(w, ai);
        step();
        chk("idle_ack", bif.ack, 1'b0);
        chk("idle_busy", bif.busy, 1'b0);
        chk("idle_aoe", bif.a_oe, 1'b0);
    endtask

    initial begin
        int        lat;
        int        el;
        bit        w;
        bit [7:0]  d;
        bit [7:0]  ai;
        tests = 0;
        fails = 0;
        vecs[0] = '{1'b1, 8'hA5, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 8'h00, 8'h3C, 8'h3C};
        vecs[2] = '{1'b1, 8'h77, 8'h00, 8'h3C};
        vecs[3] = '{1'b1, 8'h11, 8'h00, 8'h3C};
        vecs[4] = '{1'b1, 8'h22, 8'h00, 8'h3C};
        vecs[5] = '{1'b0, 8'h00, 8'hC3, 8'hC3};
        vecs[6] = '{1'b0, 8'h00, 8'h5A, 8'h5A};
        vecs[7] = '{1'b1, 8'hFF, 8'h00, 8'h5A};
        bif.req   = 1'b0;
        bif.wr    = 1'b0;
        bif.wdata = 8'h00;
        bif.a_in  = 8'h00;
        nreset    = 1'b0;
        model_reset();
        #12;
        chk("rst_nen", bif.nen, 1'b1);
        chk("rst_dir", bif.dir, 1'b0);
        chk("rst_aoe", bif.a_oe, 1'b0);
        chk("rst_adrv", bif.a_drv, 8'h00);
        chk("rst_rdata", bif.rdata, 8'h00);
        chk("rst_ack", bif.ack, 1'b0);
        chk("rst_busy", bif.busy, 1'b0);
        nreset = 1'b1;
        step();

        for (int i = 0; i < 8; i++)
            do_txn(vecs[i].w, vecs[i].d, vecs[i].ai, vecs[i].exp_rd);

        // req held across a write then a read
        el = exp_lat(1'b1);
        bif.req   = 1'b1;
        bif.wr    = 1'b1;
        bif.wdata = 8'h66;
        step();
        lat = 1;
        while (!bif.ack && lat < 20) begin
            step();
            lat++;
        end
        chk("held_wr_latency", lat, el);
        model_done(1'b1, 8'h00);
        bif.wr   = 1'b0;
        bif.a_in = 8'h99;
        chk("held_ack_busy", bif.busy, 1'b1);
        step();
        chk("held_gap_busy", bif.busy, 1'b0);
        chk("held_gap_ack", bif.ack, 1'b0);
        el = exp_lat(1'b0);
        step();
        chk("held_rd_busy", bif.busy, 1'b1);
        chk("held_rd_dir", bif.dir, 1'b0);
        chk("held_rd_aoe", bif.a_oe, 1'b0);
        bif.req = 1'b0;
        lat = 1;
        while (!bif.ack && lat < 20) begin
            step();
            lat++;
        end
        chk("held_rd_latency", lat, el);
        chk("held_rd_rdata", bif.rdata, 8'h99);
        model_done(1'b0, 8'h99);
        step();

        // reset in the middle of DRIVE
        bif.req   = 1'b1;
        bif.wr    = 1'b1;
        bif.wdata = 8'h5A;
        step();
        bif.req = 1'b0;
        step();
        chk("mid_nen_low", bif.nen, 1'b0);
        #2;
        nreset = 1'b0;
        #1;
        chk("mid_rst_nen", bif.nen, 1'b1);
        chk("mid_rst_aoe", bif.a_oe, 1'b0);
        chk("mid_rst_busy", bif.busy, 1'b0);
        chk("mid_rst_rdata", bif.rdata, 8'h00);
        model_reset();
        @(posedge clk);
        #2;
        nreset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_no_ack", bif.ack, 1'b0);
        end
        do_txn(1'b1, 8'hC0, 8'h00, 8'h00);

        // random transactions vs. reference model
        for (int i = 0; i < 30; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
            w  = 1'($urandom);
            d  = 8'($urandom);
            ai = 8'($urandom);
            do_txn(w, d, ai, w ? m_rd : ai);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
